counter_ctrl: RTL
=================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of the count and limit datapath.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately.
REQ-004 Port: start  input  1  one-cycle request to (re)start counting; samples limit and mode.
REQ-005 Port: stop  input  1  one-cycle request to abort counting and return to IDLE.
REQ-006 Port: mode  input  1  0 = one-shot, 1 = periodic; sampled on accepted start.
REQ-007 Port: limit  input  WIDTH  terminal count; sampled on accepted start.
REQ-008 Port: count  output  WIDTH  current count value, registered.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: tick  output  1  registered one-cycle pulse at each terminal-count event.
REQ-011 Port: done  output  1  level, high while in HOLD (one-shot completed).

Function
REQ-012 The controller SHALL implement three states, IDLE, RUN and HOLD, and internal registers limit_q and mode_q.
REQ-013 An advance cycle SHALL be every RUN cycle, unless narrowed by REQ-026.
REQ-014 IDLE: count = 0, busy = 0, done = 0; start = 1 -> limit_q <= limit, mode_q <= mode, count <= 0, next state RUN.
REQ-015 RUN advance with count != limit_q: count <= count + 1, with no wrap below limit_q.
REQ-016 RUN advance with count == limit_q and mode_q = 1: count <= 0, tick <= 1 in the next cycle, stay in RUN; period = limit_q + 1 advance cycles.
REQ-017 RUN advance with count == limit_q and mode_q = 0: count holds at limit_q, tick <= 1 in the next cycle, next state HOLD.
REQ-018 limit_q = 0: periodic mode SHALL tick on every advance cycle; one-shot SHALL enter HOLD on the first advance cycle.
REQ-019 HOLD: count = limit_q, done = 1, busy = 0; the block SHALL stay in HOLD until start or stop.
REQ-020 stop = 1 in any state: next state IDLE, count <= 0, and no tick is generated for that cycle.
REQ-021 stop SHALL take priority over start when both are asserted in the same cycle.
REQ-022 start in RUN or HOLD (without stop): limit_q and mode_q are resampled, count <= 0, next state RUN, and any terminal event in that cycle is discarded.
REQ-023 tick SHALL be high for exactly one cycle per terminal event and 0 at all other times.
REQ-024 The increment SHALL be modulo 2^WIDTH; count = 2^WIDTH-1 is reachable only when limit_q = 2^WIDTH-1.

Reset
REQ-025 While reset = 0: state = IDLE, count = 0, busy = 0, tick = 0, done = 0, limit_q = 0, mode_q = 0, and prescaler state = 0; reset mid-RUN SHALL abort with no tick.

Configuration
REQ-026 With macro COUNTER_CTRL_PRESCALE_EN defined: add input presc (4 bits), sampled into presc_q on accepted start; an internal divider counts 0..presc_q, restarts at 0 on start, and an advance cycle occurs only when the divider equals presc_q, giving a period of (limit_q+1)*(presc_q+1) clocks.
REQ-027 Without COUNTER_CTRL_PRESCALE_EN: no presc port and no divider logic; every RUN cycle is an advance cycle.

Verification
REQ-028 Reset pulse low mid-RUN with count = 5 -> all outputs 0 immediately, state IDLE, no tick.
REQ-029 start with mode = 1, limit = 3 -> count sequence 0,1,2,3,0,1,...; tick high when count returns to 0, every 4 clocks; busy = 1 throughout.
REQ-030 start with mode = 0, limit = 2 -> count 0,1,2 then holds at 2; one tick; done = 1, busy = 0; a second start restarts from 0.
REQ-031 start and stop together in RUN -> IDLE next cycle, count = 0, no tick; start with limit = 0, mode = 1 -> tick every cycle.
REQ-032 start with mode = 1, limit = 255 -> count wraps 255 -> 0 with a tick; a start at count = 100 restarts from 0 with the new limit.
REQ-033 With COUNTER_CTRL_PRESCALE_EN, presc = 2, limit = 1, mode = 1 -> count changes every 3 clocks; tick every 6 clocks.

Source files
------------

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/stop terminal counter with one-shot and periodic modes
// Optional clock prescaler on advance cycles: define COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
    input  logic [3:0]       presc,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             busy_q;
    logic             tick_q;
    logic             done_q;
    logic             advance;
    logic             at_limit;

    assign at_limit = (count_q == limit_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [3:0] presc_q;
    logic [3:0] div_q;
    logic [3:0] div_d;

    assign advance = (state_q == RUN) && (div_q == presc_q);

    always_comb begin
        div_d = div_q;
        if (state_q == RUN) begin
            div_d = (div_q == presc_q) ? 4'd0 : div_q + 4'd1;
        end
        if (stop || start) begin
            div_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 4'd0;
            div_q   <= 4'd0;
        end else begin
            div_q <= div_d;
            if (start && !stop) begin
                presc_q <= presc;
            end
        end
    end
`else
    assign advance = (state_q == RUN);
`endif

    // stop outranks start, and both outrank a terminal event in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (start) begin
                state_q <= RUN;
                limit_q <= limit;
                mode_q  <= mode;
                count_q <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (advance) begin
                if (at_limit) begin
                    tick_q <= 1'b1;
                    if (mode_q) begin
                        count_q <= '0;
                    end else begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tick  = tick_q;
    assign done  = done_q;

endmodule
